// File: rtl/utopia_tx_arbiter.sv
// Per-Tx-port cell arbiter: round-robin grant of whole ATM cells among NumRx requesters,
// with a watchdog that aborts a cell when byte_valid stalls for TimeoutCyc cycles.
module utopia_tx_arbiter #(
    parameter int unsigned NumRx      = 4,
    parameter int unsigned CellBytes  = 53,
    parameter int unsigned TimeoutCyc = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NumRx-1:0]         req,
    input  logic                     tx_ready,
    input  logic                     byte_valid,
    output logic [NumRx-1:0]         gnt,
    output logic [$clog2(NumRx)-1:0] gnt_id,
    output logic                     busy,
    output logic                     cell_done,
    output logic                     abort,
    output logic [15:0]              cells_fwd,
    output logic [7:0]               abort_cnt
);

    localparam int unsigned IdW   = $clog2(NumRx);
    localparam int unsigned ByteW = $clog2(CellBytes);
    localparam int unsigned IdleW = $clog2(TimeoutCyc);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StXfer = 2'd1;
    localparam logic [1:0] StGap  = 2'd2;

    localparam logic [ByteW-1:0] LastByte = ByteW'(CellBytes - 1);
    localparam logic [IdleW-1:0] LastIdle = IdleW'(TimeoutCyc - 1);
    localparam logic [IdW-1:0]   LastId   = IdW'(NumRx - 1);

    logic [1:0]       state_q, state_d;
    logic [IdW-1:0]   ptr_q, ptr_d;
    logic [ByteW-1:0] byte_cnt_q, byte_cnt_d;
    logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
    logic [NumRx-1:0] gnt_q, gnt_d;
    logic [IdW-1:0]   gnt_id_q, gnt_id_d;
    logic             cell_done_q, cell_done_d;
    logic             abort_q, abort_d;
    logic [15:0]      cells_fwd_q, cells_fwd_d;
    logic [7:0]       abort_cnt_q, abort_cnt_d;

    logic             win_found;
    logic [IdW-1:0]   win_id;
    logic [IdW-1:0]   ptr_after;

    // Round-robin scan starting at ptr; explicit modulo keeps non-power-of-2 NumRx in range.
    always_comb begin
        int unsigned idx_full;
        logic [IdW-1:0] idx;
        win_found = 1'b0;
        win_id    = '0;
        for (int unsigned k = 0; k < NumRx; k++) begin
            idx_full = (int'(ptr_q) + k) % NumRx;
            idx      = IdW'(idx_full);
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    assign ptr_after = (gnt_id_q == LastId) ? '0 : gnt_id_q + IdW'(1);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        byte_cnt_d  = byte_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        cell_done_d = 1'b0;
        abort_d     = 1'b0;
        cells_fwd_d = cells_fwd_q;
        abort_cnt_d = abort_cnt_q;

        case (state_q)
            StIdle: begin
                gnt_d = '0;
                if (tx_ready && win_found) begin
                    gnt_d      = NumRx'(1) << win_id;
                    gnt_id_d   = win_id;
                    byte_cnt_d = '0;
                    idle_cnt_d = '0;
                    state_d    = StXfer;
                end
            end
            StXfer: begin
                if (byte_valid) begin
                    idle_cnt_d = '0;
                    if (byte_cnt_q == LastByte) begin
                        gnt_d       = '0;
                        byte_cnt_d  = '0;
                        cell_done_d = 1'b1;
                        cells_fwd_d = cells_fwd_q + 16'd1;
                        ptr_d       = ptr_after;
                        state_d     = StGap;
                    end else begin
                        byte_cnt_d = byte_cnt_q + ByteW'(1);
                    end
                end else if (idle_cnt_q == LastIdle) begin
                    gnt_d      = '0;
                    byte_cnt_d = '0;
                    idle_cnt_d = '0;
                    abort_d    = 1'b1;
                    if (abort_cnt_q != 8'hFF) begin
                        abort_cnt_d = abort_cnt_q + 8'd1;
                    end
                    ptr_d   = ptr_after;
                    state_d = StGap;
                end else begin
                    idle_cnt_d = idle_cnt_q + IdleW'(1);
                end
            end
            StGap: begin
                gnt_d   = '0;
                state_d = StIdle;
            end
            default: begin
                gnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            byte_cnt_q  <= '0;
            idle_cnt_q  <= '0;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            cell_done_q <= 1'b0;
            abort_q     <= 1'b0;
            cells_fwd_q <= '0;
            abort_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            byte_cnt_q  <= byte_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            cell_done_q <= cell_done_d;
            abort_q     <= abort_d;
            cells_fwd_q <= cells_fwd_d;
            abort_cnt_q <= abort_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign busy      = (state_q == StXfer);
    assign cell_done = cell_done_q;
    assign abort     = abort_q;
    assign cells_fwd = cells_fwd_q;
    assign abort_cnt = abort_cnt_q;

endmodule
